// File: rtl/pts_key.sv
// pts_key: parallel-to-serial key converter for the byte-serial AES datapath.
// A start pulse in IDLE leads to one LOAD cycle that captures the key.
// SHIFT then streams NBYTES bytes on z with ready high for each valid byte.
// Build option PTS_KEY_LSB_FIRST_EN emits the least-significant byte first.
// Without it the most-significant byte comes first. Timing is the same in both builds.
module pts_key #(
    parameter int KEY_W  = 128,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  a,
    output logic [BYTE_W-1:0] z,
    output logic              ready
);

    localparam int NBYTES = KEY_W / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t           state;
    logic [KEY_W-1:0] shreg;
    logic [CNT_W-1:0] cnt;

    // Control FSM, shift register, beat counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            z     <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    z     <= '0;
                    ready <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
`ifdef PTS_KEY_LSB_FIRST_EN
                    z     <= a[BYTE_W-1:0];
                    shreg <= a >> BYTE_W;
`else
                    z     <= a[KEY_W-1 -: BYTE_W];
                    shreg <= a << BYTE_W;
`endif
                    cnt   <= CNT_W'(1);
                    ready <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == CNT_W'(NBYTES)) begin
                        // The last byte has already been on z for one cycle.
                        z     <= '0;
                        ready <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
`ifdef PTS_KEY_LSB_FIRST_EN
                        z     <= shreg[BYTE_W-1:0];
                        shreg <= shreg >> BYTE_W;
`else
                        z     <= shreg[KEY_W-1 -: BYTE_W];
                        shreg <= shreg << BYTE_W;
`endif
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    z     <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pts_key.sv
// tb_pts_key: directed bench for pts_key with a byte scoreboard.
// It covers reset, a basic stream, start asserted while busy, reset in mid-stream, and back-to-back conversions.
module tb_pts_key;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] a;
    logic [7:0]   z;
    logic         ready;

    int unsigned passed;
    int unsigned total;
    logic [7:0]  exp_q[$];

    localparam logic [127:0] K0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] K2 = 128'hdeadbeef0123456789abcdeffedcba98;

    pts_key #(.KEY_W(128), .BYTE_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .z     (z),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected order of the stream, independent of how the DUT shifts.
    task automatic push_key(input logic [127:0] k);
        for (int i = 0; i < 16; i++) begin
`ifdef PTS_KEY_LSB_FIRST_EN
            exp_q.push_back(k[8*i +: 8]);
`else
            exp_q.push_back(k[127 - 8*i -: 8]);
`endif
        end
    endtask

    // This task is called in the LOAD cycle, i.e. after the edge that sampled start.
    // busy_at = beat on which start is pulsed again, or -1 for none.
    // hold = level of start during the whole burst.
    task automatic load_and_stream(input logic [127:0] k, input int busy_at, input logic hold);
        logic [7:0] e;
        a     = k;
        start = hold;
        push_key(k);
        chk("load_ready", {7'b0, ready}, 8'h00);
        chk("load_z", z, 8'h00);
        tick();
        a = rnd128();
        for (int i = 0; i < 16; i++) begin
            start = hold || (i == busy_at);
            chk($sformatf("beat%0d_ready", i), {7'b0, ready}, 8'h01);
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 8'hxx, 8'h00);
                e = 8'h00;
            end else begin
                e = exp_q.pop_front();
            end
            chk($sformatf("beat%0d_z", i), z, e);
            tick();
        end
        start = hold;
        chk("after_ready", {7'b0, ready}, 8'h00);
        chk("after_z", z, 8'h00);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b0;
        start  = 1'b1;
        a      = rnd128();

        // Reset held while start is high: outputs stay zero
        for (int i = 0; i < 4; i++) begin
            tick();
            a = rnd128();
            chk("rst_ready", {7'b0, ready}, 8'h00);
            chk("rst_z", z, 8'h00);
        end
        start = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", {7'b0, ready}, 8'h00);
        end

        // Basic conversion, MSB first in the default build
        start = 1'b1;
        a     = rnd128();
        tick();
        load_and_stream(K0, -1, 1'b0);
        tick();
        chk("basic_idle_ready", {7'b0, ready}, 8'h00);
        chk("basic_idle_z", z, 8'h00);

        // start pulsed during beat 5 is ignored
        start = 1'b1;
        tick();
        load_and_stream(K0, 5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_no_second", {7'b0, ready}, 8'h00);
        end

        // Reset asserted during beat 8 aborts the stream asynchronously
        start = 1'b1;
        tick();
        a     = K0;
        start = 1'b0;
        push_key(K0);
        tick();
        a = rnd128();
        for (int i = 0; i < 8; i++) begin
            chk("pre_abort_z", z, exp_q.pop_front());
            tick();
        end
        chk("beat8_ready", {7'b0, ready}, 8'h01);
        #2 rst = 1'b0;
        #1;
        chk("abort_ready", {7'b0, ready}, 8'h00);
        chk("abort_z", z, 8'h00);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (ready !== 1'b0 || z !== 8'h00) chk("abort_idle", z | {7'b0, ready}, 8'h00);
        end
        chk("abort_idle_end", {7'b0, ready}, 8'h00);
        start = 1'b1;
        a     = rnd128();
        tick();
        load_and_stream(K0, -1, 1'b0);

        // start held high: two bursts separated by the IDLE and LOAD cycles
        tick();
        start = 1'b1;
        tick();
        load_and_stream(K1, -1, 1'b1);
        tick();
        load_and_stream(K2, -1, 1'b0);
        tick();
        chk("b2b_end_ready", {7'b0, ready}, 8'h00);
        tick();
        chk("b2b_end_ready2", {7'b0, ready}, 8'h00);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
